// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with a single-outstanding data bus handshake.
//
// Loads and stores are issued on the data bus. If the bus answers in the same cycle,
// the access finishes without stalling. If it does not, the bus fields are captured and
// held stable in a WAIT state until ready, and o_stall freezes the upstream stages.
// The stage produces the write-back register (o_wb_data/o_w_idx/o_wb_en) and a
// combinational forward value (o_mem_fw_data) for the execute stage.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   i_alu_res/i_rs2      address or ALU result / store data
//   i_mem_w_en           store; i_wb_sel==01 marks a load
//   i_func3              access size and sign
//   i_pc4, i_w_idx       PC+4 and destination register index
//   i_wb_sel, i_wb_en    write-back source (00 ALU, 01 load, 10 PC+4) and enable
//   o_dmem_*/i_dmem_*    data bus request/response
//   o_stall              freezes fetch/decode/execute
//   o_mem_fw_data        forward value to execute
//   o_wb_data/o_w_idx/o_wb_en  registered write-back
//   o_misaligned         one-cycle flag for a dropped misaligned access
//
// Build option: define MISALIGN_DETECT_EN to drop misaligned halfword/word accesses and
// flag them on o_misaligned. Without it, low address bits beyond the access size are
// ignored and o_misaligned is tied low.

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_alu_res,
    input  logic [31:0] i_rs2,
    input  logic        i_mem_w_en,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_pc4,
    input  logic [4:0]  i_w_idx,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_wb_en,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic [31:0] o_mem_fw_data,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_w_idx,
    output logic        o_wb_en,
    output logic        o_misaligned
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [1:0]  lane_q;

    logic [31:0] wb_data_q;
    logic [4:0]  w_idx_q;
    logic        wb_en_q;

    logic        access;
    logic        mis;
    logic        req_idle;
    logic [1:0]  lane_in;
    logic [31:0] addr_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    logic        bus_req;
    logic        stall;
    logic        capture;

    logic [2:0]  ld_func3;
    logic [1:0]  ld_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign access  = i_mem_w_en | (i_wb_sel == 2'b01);
    assign lane_in = i_alu_res[1:0];
    assign addr_in = {i_alu_res[31:2], 2'b00};

`ifdef MISALIGN_DETECT_EN
    always_comb begin
        mis = 1'b0;
        if (access) begin
            case (i_func3[1:0])
                2'b01:   mis = lane_in[0];
                2'b10:   mis = |lane_in;
                default: mis = 1'b0;
            endcase
        end
    end
`else
    assign mis = 1'b0;
`endif

    assign req_idle = access & ~mis;

    // Byte enables and lane-replicated store data from the incoming instruction.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = i_rs2;
        case (i_func3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << lane_in;
                wdata_in = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                be_in    = lane_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{i_rs2[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = i_rs2;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bus_req      = 1'b0;
        stall        = 1'b0;
        o_dmem_we    = i_mem_w_en;
        o_dmem_addr  = addr_in;
        o_dmem_wdata = wdata_in;
        o_dmem_be    = be_in;
        unique case (state_q)
            StIdle: begin
                bus_req = req_idle;
                stall   = req_idle & ~i_dmem_ready;
                if (stall) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                bus_req      = 1'b1;
                stall        = ~i_dmem_ready;
                o_dmem_we    = we_q;
                o_dmem_addr  = addr_q;
                o_dmem_wdata = wdata_q;
                o_dmem_be    = be_q;
                if (i_dmem_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gating with rst makes the request drop the moment reset asserts, even if the
    // upstream instruction still presents an access.
    assign o_dmem_req = rst & bus_req;
    assign o_stall    = rst & stall;

    assign capture = (state_q == StIdle) & req_idle & ~i_dmem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            func3_q <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                be_q    <= be_in;
                we_q    <= i_mem_w_en;
                func3_q <= i_func3;
                lane_q  <= lane_in;
            end
        end
    end

    // Load alignment and extension.
    assign ld_func3 = (state_q == StWait) ? func3_q : i_func3;
    assign ld_lane  = (state_q == StWait) ? lane_q  : lane_in;

    always_comb begin
        ld_byte = i_dmem_rdata[7:0];
        case (ld_lane)
            2'd0:    ld_byte = i_dmem_rdata[7:0];
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
    end

    assign ld_half = ld_lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    always_comb begin
        ld_data = i_dmem_rdata;
        case (ld_func3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    assign o_mem_fw_data = (i_wb_sel == 2'b10) ? i_pc4 : i_alu_res;

    // Write-back register; a stalled cycle inserts a bubble and holds data/index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_q <= '0;
            w_idx_q   <= '0;
            wb_en_q   <= 1'b0;
        end else if (stall) begin
            wb_en_q <= 1'b0;
        end else begin
            case (i_wb_sel)
                2'b01:   wb_data_q <= ld_data;
                2'b10:   wb_data_q <= i_pc4;
                default: wb_data_q <= i_alu_res;
            endcase
            w_idx_q <= i_w_idx;
            wb_en_q <= i_wb_en & ~mis;
        end
    end

`ifdef MISALIGN_DETECT_EN
    logic misaligned_q;

    // A misaligned access never leaves IDLE, so the flag lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= mis & (state_q == StIdle);
        end
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_wb_data = wb_data_q;
    assign o_w_idx   = w_idx_q;
    assign o_wb_en   = wb_en_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_alu_res;
    logic [31:0] i_rs2;
    logic        i_mem_w_en;
    logic [2:0]  i_func3;
    logic [31:0] i_pc4;
    logic [4:0]  i_w_idx;
    logic [1:0]  i_wb_sel;
    logic        i_wb_en;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic [31:0] i_dmem_rdata;
    logic        o_stall;
    logic [31:0] o_mem_fw_data;
    logic [31:0] o_wb_data;
    logic [4:0]  o_w_idx;
    logic        o_wb_en;
    logic        o_misaligned;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_wb_data;
    logic [4:0]  exp_w_idx;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_alu_res    (i_alu_res),
        .i_rs2        (i_rs2),
        .i_mem_w_en   (i_mem_w_en),
        .i_func3      (i_func3),
        .i_pc4        (i_pc4),
        .i_w_idx      (i_w_idx),
        .i_wb_sel     (i_wb_sel),
        .i_wb_en      (i_wb_en),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_be    (o_dmem_be),
        .i_dmem_ready (i_dmem_ready),
        .i_dmem_rdata (i_dmem_rdata),
        .o_stall      (o_stall),
        .o_mem_fw_data(o_mem_fw_data),
        .o_wb_data    (o_wb_data),
        .o_w_idx      (o_w_idx),
        .o_wb_en      (o_wb_en),
        .o_misaligned (o_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and the byte offset it starts at.
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_base(input logic [2:0] f3, input logic [1:0] lane);
        int sz = m_size(f3);
        if (sz == 1) return int'(lane);
        if (sz == 2) return lane[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lane);
        int sz = m_size(f3);
        int mask = (1 << sz) - 1;
        return 4'(mask << m_base(f3, lane));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz = m_size(f3);
        if (sz == 1) return {24'd0, rs2[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, rs2[15:0]} * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rdata);
        int sz = m_size(f3);
        logic [31:0] v = rdata >> (8 * m_base(f3, lane));
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] lane);
`ifdef MISALIGN_DETECT_EN
        int sz = m_size(f3);
        return (sz == 2 && lane[0]) || (sz == 4 && lane != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Presents one instruction, answers the bus after lat wait cycles, and checks the
    // bus, stall and write-back behaviour cycle by cycle.
    task automatic run(input logic we, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                       input logic [4:0] widx, input logic wben, input int lat_in,
                       input logic [31:0] rdata, input string tag);
        logic access;
        logic mis;
        logic req_exp;
        int   lat;
        access  = we || (sel == 2'b01);
        mis     = access && m_mis(f3, alu[1:0]);
        req_exp = access && !mis;
        lat     = req_exp ? lat_in : 0;
        @(negedge clk);
        i_mem_w_en = we;
        i_wb_sel   = sel;
        i_func3    = f3;
        i_alu_res  = alu;
        i_rs2      = rs2;
        i_pc4      = pc4;
        i_w_idx    = widx;
        i_wb_en    = wben;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            // Without a request, ready is random noise that must be ignored.
            i_dmem_ready = req_exp ? (k == lat) : 1'($urandom_range(0, 1));
            i_dmem_rdata = (k == lat) ? rdata : $urandom;
            #1;
            chk({tag, ".req"}, 32'(o_dmem_req), 32'(req_exp));
            chk({tag, ".stall"}, 32'(o_stall), 32'(req_exp && k < lat));
            chk({tag, ".fw"}, o_mem_fw_data, (sel == 2'b10) ? pc4 : alu);
            if (req_exp) begin
                chk({tag, ".addr"}, o_dmem_addr, alu & 32'hFFFF_FFFC);
                chk({tag, ".be"}, 32'(o_dmem_be), 32'(m_be(f3, alu[1:0])));
                chk({tag, ".we"}, 32'(o_dmem_we), 32'(we));
                if (we) chk({tag, ".wdata"}, o_dmem_wdata, m_wdata(f3, rs2));
            end
            @(posedge clk);
            #1;
            if (k < lat) begin
                chk({tag, ".bubble_en"}, 32'(o_wb_en), 32'd0);
                chk({tag, ".hold_data"}, o_wb_data, exp_wb_data);
                chk({tag, ".hold_idx"}, 32'(o_w_idx), 32'(exp_w_idx));
            end
        end
        if (sel == 2'b01) exp_wb_data = m_load(f3, alu[1:0], rdata);
        else if (sel == 2'b10) exp_wb_data = pc4;
        else exp_wb_data = alu;
        exp_w_idx = widx;
        chk({tag, ".wb_data"}, o_wb_data, exp_wb_data);
        chk({tag, ".w_idx"}, 32'(o_w_idx), 32'(exp_w_idx));
        chk({tag, ".wb_en"}, 32'(o_wb_en), 32'(wben && !mis));
        chk({tag, ".misaligned"}, 32'(o_misaligned), 32'(mis));
    endtask

    initial begin
        logic [2:0] ld_ops [5];
        ld_ops[0] = 3'b000; ld_ops[1] = 3'b001; ld_ops[2] = 3'b010;
        ld_ops[3] = 3'b100; ld_ops[4] = 3'b101;

        rst          = 1'b0;
        i_alu_res    = '0;
        i_rs2        = '0;
        i_mem_w_en   = 1'b0;
        i_func3      = '0;
        i_pc4        = '0;
        i_w_idx      = '0;
        i_wb_sel     = '0;
        i_wb_en      = 1'b0;
        i_dmem_ready = 1'b0;
        i_dmem_rdata = '0;
        exp_wb_data  = '0;
        exp_w_idx    = '0;

        #2;
        chk("reset.wb_data", o_wb_data, 32'd0);
        chk("reset.wb_en", 32'(o_wb_en), 32'd0);
        chk("reset.w_idx", 32'(o_w_idx), 32'd0);
        chk("reset.req", 32'(o_dmem_req), 32'd0);
        chk("reset.misaligned", 32'(o_misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, 0, 32'hDEAD_BEEF, "lw_fast");
        run(1'b1, 2'b00, 3'b000, 32'h103, 32'hA5, 32'h0, 5'd0, 1'b0, 3, 32'h0, "sb_wait");
        run(1'b0, 2'b01, 3'b000, 32'h102, 32'h0, 32'h0, 5'd5, 1'b1, 1, 32'h0080_FF00, "lb");
        run(1'b0, 2'b01, 3'b100, 32'h102, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h0080_FF00, "lbu");
        run(1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 2, 32'h8000_0000, "lh");
        run(1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h44, 5'd8, 1'b1, 0, 32'h0, "alu");
        run(1'b0, 2'b10, 3'b000, 32'h9999, 32'h0, 32'h40, 5'd1, 1'b1, 0, 32'h0, "jal");
        run(1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h0, 5'd9, 1'b1, 1, 32'h1357_9BDF, "lw_odd");

        // Reset arriving while a load waits on the bus.
        @(negedge clk);
        i_mem_w_en   = 1'b0;
        i_wb_sel     = 2'b01;
        i_func3      = 3'b010;
        i_alu_res    = 32'h200;
        i_w_idx      = 5'd4;
        i_wb_en      = 1'b1;
        i_dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wait.stall", 32'(o_stall), 32'd1);
        chk("rst_wait.req_before", 32'(o_dmem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_wait.req", 32'(o_dmem_req), 32'd0);
        chk("rst_wait.stall_off", 32'(o_stall), 32'd0);
        chk("rst_wait.wb_data", o_wb_data, 32'd0);
        chk("rst_wait.wb_en", 32'(o_wb_en), 32'd0);
        exp_wb_data = '0;
        exp_w_idx   = '0;
        @(negedge clk);
        rst = 1'b1;
        run(1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h0, 5'd4, 1'b1, 2, 32'hCAFE_F00D, "lw_after_rst");

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [1:0]  sel;
            logic [2:0]  f3;
            logic        wben;
            we = ($urandom_range(0, 3) == 0);
            if (we) begin
                sel  = 2'b00;
                f3   = ld_ops[$urandom_range(0, 2)];
                wben = 1'b0;
            end else begin
                sel  = 2'($urandom_range(0, 2));
                f3   = ld_ops[$urandom_range(0, 4)];
                wben = 1'($urandom_range(0, 1));
            end
            run(we, sel, f3, $urandom, $urandom, $urandom, 5'($urandom), wben,
                $urandom_range(0, 3), $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have EX/MEM inputs: i_alu_res in 32 address or ALU result; i_rs2 in 32 store data; i_mem_w_en in 1 store; i_func3 in 3 access size/sign; i_pc4 in 32; i_w_idx in 5; i_wb_sel in 2 (00 ALU, 01 load, 10 PC+4); i_wb_en in 1.
REQ-003 SHALL have data-bus ports: o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out 32 word-aligned; o_dmem_wdata out 32; o_dmem_be out 4; i_dmem_ready in 1; i_dmem_rdata in 32.
REQ-004 SHALL have pipeline ports: o_stall out 1 freeze fetch/decode/execute; o_mem_fw_data out 32 forward value to execute; o_wb_data out 32; o_w_idx out 5; o_wb_en out 1; o_misaligned out 1.

Function
REQ-005 SHALL treat an instruction as an access when i_mem_w_en=1 or i_wb_sel=01; others are pass-through.
REQ-006 SHALL drive o_mem_fw_data = i_wb_sel==10 ? i_pc4 : i_alu_res, combinationally.
REQ-007 SHALL implement FSM IDLE/WAIT; reset state IDLE.
REQ-008 IDLE, access: o_dmem_req=1 combinationally from inputs; i_dmem_ready=1 completes same cycle, stay IDLE; else latch addr/wdata/be/we/func3/lane, go WAIT.
REQ-009 WAIT: o_dmem_req=1 from latched values, held stable; i_dmem_ready=1 completes, return IDLE.
REQ-010 o_stall SHALL be 1 when (IDLE, access, !ready) or (WAIT, !ready); upstream holds inputs while o_stall=1.
REQ-011 o_dmem_addr = {i_alu_res[31:2],2'b00}; lane = i_alu_res[1:0].
REQ-012 Store SB: be=0001<<lane, wdata=byte replicated x4; SH: be=0011 (lane[1]=0) or 1100, wdata=halfword replicated x2; SW: be=1111, wdata=i_rs2.
REQ-013 Loads SHALL set be per REQ-012, we=0.
REQ-014 Load data: LB/LBU byte at lane, LH/LHU halfword at lane[1]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-015 WB register SHALL load on cycle with o_stall=0: o_wb_data = load data (01), i_pc4 (10), i_alu_res (00); o_w_idx=i_w_idx; o_wb_en=i_wb_en.
REQ-016 Stall cycles SHALL load o_wb_en=0 (bubble), o_wb_data/o_w_idx hold.
REQ-017 Stores SHALL write o_wb_en=i_wb_en (0 from decode); no register write.
REQ-018 i_dmem_ready while o_dmem_req=0 SHALL be ignored.

Reset
REQ-019 rst=0 SHALL immediately force: FSM IDLE, o_wb_data=0, o_w_idx=0, o_wb_en=0, o_misaligned=0, all latched bus fields 0.
REQ-020 Reset mid-WAIT SHALL abandon the transaction; o_dmem_req deasserts asynchronously.

Configuration
REQ-021 Macro MISALIGN_DETECT_EN defined: LH/LHU/SH with lane[0]=1 or LW/SW with lane!=0 SHALL issue no request, no stall, load o_wb_en=0, o_misaligned=1 for one cycle.
REQ-022 Macro undefined: low address bits beyond access size SHALL be ignored (halfword uses lane[1], word ignores lane); o_misaligned tied 0.

Verification
REQ-023 LW addr 0x100, ready=1 same cycle, rdata 0xDEADBEEF -> no stall; next cycle o_wb_data=0xDEADBEEF, o_wb_en=1.
REQ-024 SB addr 0x103, rs2 0x000000A5, ready low 3 cycles -> o_stall=1 for 3 cycles, be=1000, wdata=0xA5A5A5A5, addr=0x100 stable; o_wb_en=0.
REQ-025 LB addr 0x102 rdata 0x0080FF00 -> o_wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 rdata 0x80000000 -> 0xFFFF8000.
REQ-026 ALU op wb_sel 00 res 0x1234, then JAL wb_sel 10 pc4 0x40 -> o_wb_data 0x1234 then 0x40, no req.
REQ-027 rst asserted in WAIT -> req=0 immediately; after release, LW completes normally.
REQ-028 With MISALIGN_DETECT_EN, LW addr 0x102 -> req=0, o_misaligned=1 one cycle, o_wb_en=0; without, req=1, addr 0x100.
